// File: rtl/trace_rtl_pkg.sv
// rtl/trace_rtl_pkg.sv - shared types, command codes and width helpers for the trace decoder
package trace_rtl_pkg;

    typedef enum logic [3:0] {
        CMD_NONE,
        RD_L1D,
        WR_L1D,
        RD_L1I,
        SNP_RD,
        SNP_WR,
        SNP_RWIM,
        SNP_INV,
        CLEAR,
        PRINT,
        CMD_ILLEGAL
    } cmd_class_t;

    localparam int NUM_CLASSES = 11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_CLR,
        ST_WAIT_PRN
    } dec_state_t;

    localparam int unsigned CMD_CODE_RD_L1D   = 0;
    localparam int unsigned CMD_CODE_WR_L1D   = 1;
    localparam int unsigned CMD_CODE_RD_L1I   = 2;
    localparam int unsigned CMD_CODE_SNP_RD   = 3;
    localparam int unsigned CMD_CODE_SNP_WR   = 4;
    localparam int unsigned CMD_CODE_SNP_RWIM = 5;
    localparam int unsigned CMD_CODE_SNP_INV  = 6;
    localparam int unsigned CMD_CODE_CLEAR    = 8;
    localparam int unsigned CMD_CODE_PRINT    = 9;

    function automatic cmd_class_t decode_cmd(input int unsigned code);
        cmd_class_t cls;
        case (code)
            CMD_CODE_RD_L1D:   cls = RD_L1D;
            CMD_CODE_WR_L1D:   cls = WR_L1D;
            CMD_CODE_RD_L1I:   cls = RD_L1I;
            CMD_CODE_SNP_RD:   cls = SNP_RD;
            CMD_CODE_SNP_WR:   cls = SNP_WR;
            CMD_CODE_SNP_RWIM: cls = SNP_RWIM;
            CMD_CODE_SNP_INV:  cls = SNP_INV;
            CMD_CODE_CLEAR:    cls = CLEAR;
            CMD_CODE_PRINT:    cls = PRINT;
            default:           cls = CMD_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic int calc_offset_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_set_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int calc_tag_bits(input int addr_bits, input int line_bytes, input int num_sets);
        return addr_bits - calc_set_bits(num_sets) - calc_offset_bits(line_bytes);
    endfunction

endpackage

// File: rtl/trace_cmd_decoder_if.sv
// rtl/trace_cmd_decoder_if.sv - raw record input and decoded record output handshakes
interface trace_cmd_decoder_if #(
    parameter int PHYSICAL_ADDR_BITS = 32,
    parameter int LINE_BYTES         = 64,
    parameter int NUM_SETS           = 32768,
    parameter int CMD_BITS           = 4
);
    import trace_rtl_pkg::*;

    localparam int OFFSET_BITS = calc_offset_bits(LINE_BYTES);
    localparam int SET_BITS    = calc_set_bits(NUM_SETS);
    localparam int TAG_BITS    = calc_tag_bits(PHYSICAL_ADDR_BITS, LINE_BYTES, NUM_SETS);

    logic                          in_valid;
    logic                          in_ready;
    logic [CMD_BITS-1:0]           in_cmd;
    logic [PHYSICAL_ADDR_BITS-1:0] in_addr;

    logic                          out_valid;
    logic                          out_ready;
    cmd_class_t                    out_class;
    logic [TAG_BITS-1:0]           out_tag;
    logic [SET_BITS-1:0]           out_set;
    logic [OFFSET_BITS-1:0]        out_offset;
    logic                          out_illegal;

    modport master (
        output in_valid, in_cmd, in_addr, out_ready,
        input  in_ready, out_valid, out_class, out_tag, out_set, out_offset, out_illegal
    );

    modport slave (
        input  in_valid, in_cmd, in_addr, out_ready,
        output in_ready, out_valid, out_class, out_tag, out_set, out_offset, out_illegal
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - parametrised synchronous FIFO with occupancy count and head read-through
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_cmd_decoder.sv
// rtl/trace_cmd_decoder.sv - buffers trace records, decodes class and address fields, stalls on clear/print
// Optional per-class transfer counters are built when TRACE_STATS_EN is defined.
module trace_cmd_decoder #(
    parameter int PHYSICAL_ADDR_BITS = 32,
    parameter int LINE_BYTES         = 64,
    parameter int NUM_SETS           = 32768,
    parameter int CMD_BITS           = 4,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    trace_cmd_decoder_if.slave            bus,
    input  logic                          op_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef TRACE_STATS_EN
    ,
    input  logic [3:0]                    stats_sel,
    output logic [31:0]                   stats_cnt
`endif
);
    import trace_rtl_pkg::*;

    localparam int OFFSET_BITS = calc_offset_bits(LINE_BYTES);
    localparam int SET_BITS    = calc_set_bits(NUM_SETS);
    localparam int TAG_BITS    = calc_tag_bits(PHYSICAL_ADDR_BITS, LINE_BYTES, NUM_SETS);
    localparam int FW          = CMD_BITS + PHYSICAL_ADDR_BITS;

    dec_state_t state_q;
    dec_state_t state_d;

    logic                          push_in;
    logic                          xfer;
    logic                          going_wait;
    logic                          run_now;
    logic                          load;
    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic [FW-1:0]                 fifo_rdata;
    logic [CMD_BITS-1:0]           src_cmd;
    logic [PHYSICAL_ADDR_BITS-1:0] src_addr;
    cmd_class_t                    src_class;

    trace_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({bus.in_cmd, bus.in_addr}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.in_ready = !fifo_full;
    assign push_in      = bus.in_valid && bus.in_ready;
    assign xfer         = bus.out_valid && bus.out_ready;
    assign going_wait   = xfer && ((bus.out_class == CLEAR) || (bus.out_class == PRINT));

    // an empty FIFO is bypassed so a fresh record reaches the output one cycle after its push
    assign {src_cmd, src_addr} = fifo_empty ? {bus.in_cmd, bus.in_addr} : fifo_rdata;
    assign src_class = decode_cmd(32'(src_cmd));

    // op_done releases the stall and lets the next record load on the same edge
    assign run_now   = (state_q == ST_RUN) || op_done;
    assign load      = run_now && (!bus.out_valid || bus.out_ready) && !going_wait
                       && (!fifo_empty || push_in);
    assign fifo_pop  = load && !fifo_empty;
    assign fifo_push = push_in && !(load && fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_RUN);
        case (state_q)
            ST_RUN: begin
                if (going_wait) begin
                    state_d = (bus.out_class == CLEAR) ? ST_WAIT_CLR : ST_WAIT_PRN;
                end
            end
            ST_WAIT_CLR, ST_WAIT_PRN: begin
                if (op_done) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_class   <= CMD_NONE;
            bus.out_tag     <= '0;
            bus.out_set     <= '0;
            bus.out_offset  <= '0;
            bus.out_illegal <= 1'b0;
        end else if (load) begin
            bus.out_valid   <= 1'b1;
            bus.out_class   <= src_class;
            bus.out_tag     <= src_addr[PHYSICAL_ADDR_BITS-1 -: TAG_BITS];
            bus.out_set     <= src_addr[OFFSET_BITS +: SET_BITS];
            bus.out_offset  <= src_addr[OFFSET_BITS-1:0];
            bus.out_illegal <= (src_class == CMD_ILLEGAL);
        end else if (xfer) begin
            bus.out_valid   <= 1'b0;
        end
    end

`ifdef TRACE_STATS_EN
    logic [31:0] stat_q [NUM_CLASSES];

    // a transferred CLEAR wipes every counter and then counts itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) stat_q[i] <= '0;
            stats_cnt <= '0;
        end else begin
            if (xfer) begin
                if (bus.out_class == CLEAR) begin
                    for (int i = 0; i < NUM_CLASSES; i++) begin
                        stat_q[i] <= (i == int'(CLEAR)) ? 32'd1 : 32'd0;
                    end
                end else if (stat_q[bus.out_class] != '1) begin
                    stat_q[bus.out_class] <= stat_q[bus.out_class] + 32'd1;
                end
            end
            stats_cnt <= (stats_sel < 4'(NUM_CLASSES)) ? stat_q[stats_sel] : 32'd0;
        end
    end
`endif

endmodule

// File: tb/tb_trace_cmd_decoder.sv
// tb/tb_trace_cmd_decoder.sv - directed self-checking bench for trace_cmd_decoder
module tb_trace_cmd_decoder;
    import trace_rtl_pkg::*;

    localparam int PA = 32;
    localparam int LB = 64;
    localparam int NS = 32768;
    localparam int CB = 4;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_done = 1'b0;
    logic       busy;
    logic [2:0] fifo_count;
    int         n_checks = 0;
    int         n_pass = 0;
`ifdef TRACE_STATS_EN
    logic [3:0]  stats_sel = 4'd0;
    logic [31:0] stats_cnt;
`endif

    always #5 clk = ~clk;

    trace_cmd_decoder_if #(
        .PHYSICAL_ADDR_BITS (PA),
        .LINE_BYTES         (LB),
        .NUM_SETS           (NS),
        .CMD_BITS           (CB)
    ) bus ();

    trace_cmd_decoder #(
        .PHYSICAL_ADDR_BITS (PA),
        .LINE_BYTES         (LB),
        .NUM_SETS           (NS),
        .CMD_BITS           (CB),
        .FIFO_DEPTH         (FD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .op_done    (op_done),
        .busy       (busy),
        .fifo_count (fifo_count)
`ifdef TRACE_STATS_EN
        ,
        .stats_sel  (stats_sel),
        .stats_cnt  (stats_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic [3:0] cmd, input logic [31:0] addr);
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_addr  = addr;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_cmd    = '0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_class", 32'(bus.out_class), 32'(CMD_NONE));
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // single record, minimum latency and address slicing
        push_rec(4'd0, 32'h1001_9D94);
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_class", 32'(bus.out_class), 32'(RD_L1D));
        chk("lat_tag", 32'(bus.out_tag), 32'h080);
        chk("lat_set", 32'(bus.out_set), 32'h0676);
        chk("lat_offset", 32'(bus.out_offset), 32'h14);
        chk("lat_illegal", 32'(bus.out_illegal), 32'd0);
        tick();
        chk("lat_drain", 32'(bus.out_valid), 32'd0);

        // backpressure fills the FIFO; record k uses cmd k-1 and set k
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) push_rec(4'(k - 1), 32'(k) << 6);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_class", 32'(bus.out_class), 32'(RD_L1D));
        tick();
        chk("hold_class", 32'(bus.out_class), 32'(RD_L1D));
        chk("hold_set", 32'(bus.out_set), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("order_valid", 32'(bus.out_valid), 32'd1);
            chk("order_class", 32'(bus.out_class), 32'(k));
            chk("order_set", 32'(bus.out_set), 32'(k));
        end
        tick();
        chk("order_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("order_drain_count", 32'(fifo_count), 32'd0);

        // CLEAR stalls the stream until op_done
        push_rec(4'd8, 32'h0);
        chk("clr_class", 32'(bus.out_class), 32'(CLEAR));
        push_rec(4'd1, 32'h40);
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_count", 32'(fifo_count), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("clr_stall", 32'(bus.out_valid), 32'd0);
        end
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("clr_resume_valid", 32'(bus.out_valid), 32'd1);
        chk("clr_resume_class", 32'(bus.out_class), 32'(WR_L1D));
        chk("clr_resume_busy", 32'(busy), 32'd0);
        tick();
        chk("clr_drain", 32'(bus.out_valid), 32'd0);

        // undefined codes pass through flagged
        push_rec(4'd7, 32'h80);
        chk("ill7_class", 32'(bus.out_class), 32'(CMD_ILLEGAL));
        chk("ill7_flag", 32'(bus.out_illegal), 32'd1);
        push_rec(4'd15, 32'hC0);
        chk("ill15_valid", 32'(bus.out_valid), 32'd1);
        chk("ill15_class", 32'(bus.out_class), 32'(CMD_ILLEGAL));
        chk("ill15_flag", 32'(bus.out_illegal), 32'd1);
        chk("ill15_busy", 32'(busy), 32'd0);
        tick();
        chk("ill_drain", 32'(bus.out_valid), 32'd0);

        // reset during WAIT_PRN with records buffered
        push_rec(4'd9, 32'h0);
        chk("prn_class", 32'(bus.out_class), 32'(PRINT));
        push_rec(4'd0, 32'h40);
        push_rec(4'd1, 32'h80);
        push_rec(4'd2, 32'hC0);
        chk("prn_busy", 32'(busy), 32'd1);
        chk("prn_count", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_stale", 32'(bus.out_valid), 32'd0);
        end

`ifdef TRACE_STATS_EN
        for (int i = 0; i < 3; i++) push_rec(4'd0, 32'h0);
        push_rec(4'd8, 32'h0);
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        push_rec(4'd0, 32'h0);
        tick();
        stats_sel = 4'(RD_L1D);
        tick();
        tick();
        chk("stats_rd_l1d", stats_cnt, 32'd1);
        stats_sel = 4'(CLEAR);
        tick();
        tick();
        chk("stats_clear", stats_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
